// File: rtl/tpu_arb_pkg.sv
// Shared types and default widths for the TPU weight-ROM / MultAdder arbiter.
package tpu_arb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 1024;
    localparam int DEF_RES_W  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    function automatic logic [1:0] id2oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tpu_share_arbiter_if.sv
// Requester-side bundle: two layer engines sharing the weight ROM and MultAdder.
interface tpu_share_arbiter_if
    import tpu_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W
);
    logic [1:0]             req;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0]             opr_vld;
    logic [1:0][DATA_W-1:0] opr1;
    logic [1:0][DATA_W-1:0] opr2;
    logic [1:0]             gnt;
    logic [DATA_W-1:0]      rdata;
    logic [1:0]             rdata_vld;
    logic [RES_W-1:0]       res;
    logic [1:0]             res_vld;
    logic [1:0]             ovf_sticky;
    logic [1:0]             ovf_clr;

    modport master (
        output req, addr, opr_vld, opr1, opr2, ovf_clr,
        input  gnt, rdata, rdata_vld, res, res_vld, ovf_sticky
    );

    modport slave (
        input  req, addr, opr_vld, opr1, opr2, ovf_clr,
        output gnt, rdata, rdata_vld, res, res_vld, ovf_sticky
    );
endinterface

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] pick
);
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_owner ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end
endmodule

// File: rtl/tpu_share_arbiter.sv
// Registered, burst-locked round-robin arbiter for the shared weight ROM and
// combinational MultAdder; read data and MAC results are tagged per requester.
module tpu_share_arbiter
    import tpu_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RES_W     = DEF_RES_W,
    parameter int MAX_BURST = 64
) (
    input  logic                 clk,
    input  logic                 iRst,
    tpu_share_arbiter_if.slave   rq,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_dout,
    output logic [DATA_W-1:0]    mac_in1,
    output logic [DATA_W-1:0]    mac_in2,
    input  logic [RES_W-1:0]     mac_out,
    input  logic                 mac_ovf
);
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_e       state;
    logic             last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic [1:0]       pick;
    logic [1:0]       acc_vec;
    logic             acc;
    logic             acc_id;
    logic             mac_beat;
    logic             owner;
    logic             burst_done;
    tag_t             tag_s1;
    tag_t             tag_s2;

    arb_rr_pick u_pick (
        .req        (rq.req),
        .last_owner (last_owner),
        .pick       (pick)
    );

    assign acc_vec  = rq.req & rq.gnt;
    assign acc      = |acc_vec;
    assign acc_id   = acc_vec[1];
    assign mac_beat = acc & rq.opr_vld[acc_id];
    assign owner    = (state == ST_OWN1);

    // The count includes the beat accepted this cycle, so a burst is exactly MAX_BURST beats.
    assign beat_cnt_nxt = beat_cnt + CNT_W'(acc);
    assign burst_done   = (MAX_BURST != 0) && (beat_cnt_nxt == CNT_W'(MAX_BURST));

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            rq.gnt     <= 2'b00;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked blocks; all reads see pre-edge values.
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (pick[0]) begin
                        state  <= ST_OWN0;
                        rq.gnt <= 2'b01;
                    end else if (pick[1]) begin
                        state  <= ST_OWN1;
                        rq.gnt <= 2'b10;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!rq.req[owner] || (burst_done && rq.req[~owner])) begin
                        state      <= ST_IDLE;
                        rq.gnt     <= 2'b00;
                        last_owner <= owner;
                        beat_cnt   <= '0;
                    end else begin
                        beat_cnt <= beat_cnt_nxt;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rq.gnt <= 2'b00;
                end
            endcase
        end
    end

    // ROM port, tag pipe and MAC result capture.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            rom_en        <= 1'b0;
            rom_addr      <= '0;
            tag_s1        <= '0;
            tag_s2        <= '0;
            rq.res        <= '0;
            rq.res_vld    <= 2'b00;
            rq.ovf_sticky <= 2'b00;
        end else begin
            if (acc) begin
                rom_en   <= 1'b1;
                rom_addr <= rq.addr[acc_id];
            end
            tag_s1 <= '{vld: acc, id: acc_id};
            tag_s2 <= tag_s1;
            if (mac_beat) rq.res <= mac_out;
            rq.res_vld    <= mac_beat ? id2oh(acc_id) : 2'b00;
            rq.ovf_sticky <= (rq.ovf_sticky & ~rq.ovf_clr)
                           | ((mac_beat && mac_ovf) ? id2oh(acc_id) : 2'b00);
        end
    end

    // Read valid follows the tag, not the current grant, so in-flight reads survive a switch.
    assign rq.rdata     = rom_dout;
    assign rq.rdata_vld = tag_s2.vld ? id2oh(tag_s2.id) : 2'b00;
    assign mac_in1      = mac_beat ? rq.opr1[acc_id] : '0;
    assign mac_in2      = mac_beat ? rq.opr2[acc_id] : '0;

endmodule

// File: tb/tb_tpu_share_arbiter.sv
// Scoreboard bench for tpu_share_arbiter with behavioural ROM and MultAdder models.
module tb_tpu_share_arbiter;
    localparam int AW = 11;
    localparam int DW = 1024;
    localparam int RW = 15;

    typedef struct {
        logic [AW-1:0] addr;
        logic          mv;
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
    } beat_t;

    typedef struct { logic id; logic [AW-1:0] addr; int due; } rd_exp_t;
    typedef struct { logic id; logic [RW-1:0] res;  int due; } mac_exp_t;
    typedef struct { int cyc; logic id; } acc_t;

    logic clk = 1'b0;
    logic iRst = 1'b1;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout = '0;
    logic [DW-1:0] mac_in1, mac_in2;
    logic [RW-1:0] mac_out;
    logic          mac_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_pulses = 0;
    logic [1:0] acc_seen = 2'b00;

    beat_t    q0[$];
    beat_t    q1[$];
    rd_exp_t  rd_q[$];
    mac_exp_t mac_q[$];
    acc_t     acc_log[$];
    logic [1:0] gnt_hist[int];
    logic [1:0] vld_hist[int];

    tpu_share_arbiter_if ifc ();

    tpu_share_arbiter #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .iRst     (iRst),
        .rq       (ifc),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .mac_in1  (mac_in1),
        .mac_in2  (mac_in2),
        .mac_out  (mac_out),
        .mac_ovf  (mac_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {32{5'h1B, a, 5'h04, ~a}};
    endfunction

    function automatic logic [15:0] mac_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a[RW-1:0]} + {1'b0, b[RW-1:0]};
    endfunction

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic beat_t mk_beat(input int a, input logic mv, input logic [RW-1:0] lo1,
                                      input logic [RW-1:0] lo2);
        beat_t b;
        b.addr = AW'(a);
        b.mv   = mv;
        for (int w = 0; w < DW / 32; w++) begin
            b.o1[w*32 +: 32] = $urandom;
            b.o2[w*32 +: 32] = $urandom;
        end
        b.o1[RW-1:0] = lo1;
        b.o2[RW-1:0] = lo2;
        return b;
    endfunction

    // Behavioural block_mem (1-cycle read) and combinational TPU_MultAdd.
    always @(posedge clk) if (rom_en) rom_dout <= rom_word(rom_addr);
    assign {mac_ovf, mac_out} = mac_sum(mac_in1, mac_in2);

    // Monitor: compare outputs due this cycle, then log accepts and push expectations.
    rd_exp_t  re;
    mac_exp_t me;
    logic [1:0]    exp_rv, exp_mv, acc_now;
    logic [DW-1:0] exp_rd;
    logic [RW-1:0] exp_res;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (iRst) begin
            rd_q.delete();
            mac_q.delete();
        end
        exp_rv = 2'b00;
        exp_mv = 2'b00;
        exp_rd = '0;
        exp_res = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            re = rd_q.pop_front();
            exp_rv = oh(re.id);
            exp_rd = rom_word(re.addr);
        end
        if (mac_q.size() > 0 && mac_q[0].due == cyc) begin
            me = mac_q.pop_front();
            exp_mv = oh(me.id);
            exp_res = me.res;
        end
        checks++;
        if (ifc.rdata_vld !== exp_rv) begin
            errors++;
            $display("FAIL rdata_vld cyc=%0d got=%b exp=%b", cyc, ifc.rdata_vld, exp_rv);
        end
        if (exp_rv != 2'b00) begin
            checks++;
            if (ifc.rdata !== exp_rd) begin
                errors++;
                $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, ifc.rdata[63:0], exp_rd[63:0]);
            end
        end
        checks++;
        if (ifc.res_vld !== exp_mv) begin
            errors++;
            $display("FAIL res_vld cyc=%0d got=%b exp=%b", cyc, ifc.res_vld, exp_mv);
        end
        if (exp_mv != 2'b00) begin
            checks++;
            if (ifc.res !== exp_res) begin
                errors++;
                $display("FAIL res cyc=%0d got=%h exp=%h", cyc, ifc.res, exp_res);
            end
        end
        checks++;
        if ($countones(ifc.gnt) > 1) begin
            errors++;
            $display("FAIL gnt_onehot cyc=%0d got=%b exp=onehot_or_zero", cyc, ifc.gnt);
        end
        acc_now = ifc.req & ifc.gnt;
        acc_seen = acc_now;
        gnt_hist[cyc] = ifc.gnt;
        vld_hist[cyc] = ifc.rdata_vld;
        if (ifc.rdata_vld != 2'b00) vld_pulses++;
        if (acc_now == 2'b00) begin
            checks++;
            if (mac_in1 !== '0 || mac_in2 !== '0) begin
                errors++;
                $display("FAIL mac_in_idle cyc=%0d got=%h/%h exp=0", cyc, mac_in1[31:0], mac_in2[31:0]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (acc_now[k]) begin
                acc_log.push_back('{cyc: cyc, id: 1'(k)});
                rd_q.push_back('{id: 1'(k), addr: ifc.addr[k], due: cyc + 2});
                if (ifc.opr_vld[k]) begin
                    mac_q.push_back('{id: 1'(k), res: mac_sum(ifc.opr1[k], ifc.opr2[k])
                                      [RW-1:0], due: cyc + 1});
                    checks++;
                    if (mac_in1 !== ifc.opr1[k] || mac_in2 !== ifc.opr2[k]) begin
                        errors++;
                        $display("FAIL mac_in_route cyc=%0d got=%h/%h exp=%h/%h", cyc,
                                 mac_in1[31:0], mac_in2[31:0], ifc.opr1[k][31:0], ifc.opr2[k][31:0]);
                    end
                end
            end
        end
    end

    task automatic present();
        if (q0.size() > 0) begin
            ifc.req[0] = 1'b1;  ifc.addr[0] = q0[0].addr;  ifc.opr_vld[0] = q0[0].mv;
            ifc.opr1[0] = q0[0].o1;  ifc.opr2[0] = q0[0].o2;
        end else begin
            ifc.req[0] = 1'b0;  ifc.opr_vld[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            ifc.req[1] = 1'b1;  ifc.addr[1] = q1[0].addr;  ifc.opr_vld[1] = q1[0].mv;
            ifc.opr1[1] = q1[0].o1;  ifc.opr2[1] = q1[0].o2;
        end else begin
            ifc.req[1] = 1'b0;  ifc.opr_vld[1] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_seen[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc_seen[1] && q1.size() > 0) void'(q1.pop_front());
        present();
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
        repeat (4) step();
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        ifc.req = 2'b00;
        ifc.opr_vld = 2'b00;
        ifc.ovf_clr = 2'b00;
        iRst = 1'b1;
        repeat (2) @(posedge clk);
        #1 iRst = 1'b0;
    endtask

    task automatic check_outputs_reset(input string tag);
        checks++;
        if (ifc.gnt !== 2'b00 || rom_en !== 1'b0 || rom_addr !== '0 || ifc.rdata_vld !== 2'b00 ||
            ifc.res !== '0 || ifc.res_vld !== 2'b00 || ifc.ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL %s got gnt=%b en=%b addr=%h rv=%b res=%h resv=%b ovf=%b exp=all_zero", tag,
                     ifc.gnt, rom_en, rom_addr, ifc.rdata_vld, ifc.res, ifc.res_vld, ifc.ovf_sticky);
        end
    endtask

    task automatic test_reset();
        #3;
        check_outputs_reset("reset_values");
        do_reset();
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 4; i++) q0.push_back(mk_beat(5 + i, 1'b0, '0, '0));
        step();
        t0 = cyc + 1;
        run_drain(50);
        checks++;
        if (gnt_hist[t0] !== 2'b00 || gnt_hist[t0 + 1] !== 2'b01) begin
            errors++;
            $display("FAIL single_gnt_latency got=%b,%b exp=00,01", gnt_hist[t0], gnt_hist[t0 + 1]);
        end
        checks++;
        if (acc_log.size() != 4) begin
            errors++;
            $display("FAIL single_beats got=%0d exp=4", acc_log.size());
        end
        for (int i = 0; i < acc_log.size() && i < 4; i++) begin
            checks++;
            if (acc_log[i].cyc != t0 + 1 + i || acc_log[i].id !== 1'b0) begin
                errors++;
                $display("FAIL single_accept[%0d] got=cyc%0d/id%0d exp=cyc%0d/id0", i,
                         acc_log[i].cyc, acc_log[i].id, t0 + 1 + i);
            end
            checks++;
            if (vld_hist[t0 + 3 + i] !== 2'b01) begin
                errors++;
                $display("FAIL single_rdata_vld[%0d] got=%b exp=01", i, vld_hist[t0 + 3 + i]);
            end
        end
    endtask

    task automatic test_tie_switch();
        int t0;
        logic [1:0] exp_g [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
        do_reset();
        acc_log.delete();
        q0.push_back(mk_beat(30, 1'b0, '0, '0));
        q0.push_back(mk_beat(31, 1'b0, '0, '0));
        q1.push_back(mk_beat(40, 1'b0, '0, '0));
        q1.push_back(mk_beat(41, 1'b0, '0, '0));
        step();
        t0 = cyc + 1;
        run_drain(50);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (gnt_hist[t0 + i] !== exp_g[i]) begin
                errors++;
                $display("FAIL tie_gnt[t0+%0d] got=%b exp=%b", i, gnt_hist[t0 + i], exp_g[i]);
            end
        end
        checks++;
        if (vld_hist[t0 + 4] !== 2'b01) begin
            errors++;
            $display("FAIL inflight_after_switch got=%b exp=01", vld_hist[t0 + 4]);
        end
        checks++;
        if (acc_log.size() != 4 || acc_log[2].cyc != t0 + 5 || acc_log[2].id !== 1'b1) begin
            errors++;
            $display("FAIL tie_second_owner got=n%0d exp=n4 first1@t0+5", acc_log.size());
        end
    endtask

    task automatic test_max_burst();
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk_beat(100 + i, 1'b0, '0, '0));
            q1.push_back(mk_beat(200 + i, 1'b0, '0, '0));
        end
        step();
        run_drain(200);
        checks++;
        if (acc_log.size() != 24) begin
            errors++;
            $display("FAIL burst_beats got=%0d exp=24", acc_log.size());
        end
        for (int i = 0; i < acc_log.size() && i < 24; i++) begin
            checks++;
            if (acc_log[i].id !== 1'((i / 4) % 2) || acc_log[i].cyc - acc_log[0].cyc != i + i / 4) begin
                errors++;
                $display("FAIL burst_accept[%0d] got=id%0d@+%0d exp=id%0d@+%0d", i, acc_log[i].id,
                         acc_log[i].cyc - acc_log[0].cyc, (i / 4) % 2, i + i / 4);
            end
        end
    endtask

    task automatic test_mac_overflow();
        int n = 0;
        do_reset();
        q1.push_back(mk_beat(300, 1'b1, 15'h7FFF, 15'h0003));
        step();
        run_drain(50);
        checks++;
        if (ifc.ovf_sticky !== 2'b10 || ifc.res !== 15'h0002) begin
            errors++;
            $display("FAIL ovf_set got=%b/%h exp=10/0002", ifc.ovf_sticky, ifc.res);
        end
        // Clear is held through the accepting cycle of a second overflowing beat.
        q1.push_back(mk_beat(301, 1'b1, 15'h4000, 15'h4000));
        ifc.ovf_clr = 2'b10;
        do begin
            step();
            n++;
        end while (q1.size() != 0 && n < 50);
        ifc.ovf_clr = 2'b00;
        repeat (3) step();
        checks++;
        if (ifc.ovf_sticky !== 2'b10) begin
            errors++;
            $display("FAIL ovf_set_wins got=%b exp=10", ifc.ovf_sticky);
        end
        ifc.ovf_clr = 2'b10;
        step();
        ifc.ovf_clr = 2'b00;
        step();
        checks++;
        if (ifc.ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=00", ifc.ovf_sticky);
        end
        q0.push_back(mk_beat(302, 1'b1, 15'h0100, 15'h0023));
        step();
        run_drain(50);
        checks++;
        if (ifc.ovf_sticky !== 2'b00 || ifc.res !== 15'h0123) begin
            errors++;
            $display("FAIL mac_no_ovf got=%b/%h exp=00/0123", ifc.ovf_sticky, ifc.res);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(mk_beat(20 + i, 1'b0, '0, '0));
        repeat (4) step();
        checks++;
        if (ifc.rdata_vld !== 2'b01 || rom_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_inflight got=%b/%b exp=01/1", ifc.rdata_vld, rom_en);
        end
        iRst = 1'b1;
        q0.delete();
        q1.delete();
        ifc.req = 2'b00;
        #1;
        check_outputs_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 iRst = 1'b0;
        vld_pulses = 0;
        repeat (6) step();
        checks++;
        if (vld_pulses != 0) begin
            errors++;
            $display("FAIL post_reset_vld got=%0d exp=0", vld_pulses);
        end
    endtask

    initial begin
        ifc.req = 2'b00;
        ifc.addr = '0;
        ifc.opr_vld = 2'b00;
        ifc.opr1 = '0;
        ifc.opr2 = '0;
        ifc.ovf_clr = 2'b00;
        test_reset();
        test_single();
        test_tie_switch();
        test_max_burst();
        test_mac_overflow();
        test_reset_inflight();
        checks++;
        if (rd_q.size() != 0 || mac_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", rd_q.size(), mac_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_share_arbiter.md
# tpu_share_arbiter

Arbitrates the single weight ROM (`block_mem`, 1024-bit word, 1-cycle read) and the single combinational `TPU_MultAdd` unit between two layer engines (requester 0 = FC1, requester 1 = FC2). It replaces tri-state bus sharing with a registered, round-robin, burst-locked grant. Read data and MAC results are tagged back to the issuing requester. The block sits between the layer engines and the shared ROM/MultAdder, under the top-level TPU sequencer.

## Interface
Parameters:
- `ADDR_W`, 11: ROM address width.
- `DATA_W`, 1024: ROM word width; also the operand width.
- `RES_W`, 15: MultAdder result width.
- `MAX_BURST`, 64: maximum accepted beats per grant while the other requester is waiting. 0 means unlimited.

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `iRst`, in, 1: asynchronous, active-high reset.
- `req`, in, 2: per-requester beat request. Must be held until accepted.
- `addr`, in, 2×ADDR_W: per-requester ROM address. Requester k uses slice k.
- `opr_vld`, in, 2: the beat also carries a MAC operation.
- `opr1`, `opr2`, in, 2×DATA_W each: per-requester MAC operands.
- `gnt`, out, 2: registered; one-hot or zero.
- `rom_en`, out, 1: ROM enable to `block_mem`.
- `rom_addr`, out, ADDR_W: ROM address to `block_mem`.
- `rom_dout`, in, DATA_W: ROM data from `block_mem`.
- `mac_in1`, `mac_in2`, out, DATA_W each: operands to `TPU_MultAdd`.
- `mac_out`, in, RES_W: result from `TPU_MultAdd`.
- `mac_ovf`, in, 1: overflow from `TPU_MultAdd`.
- `rdata`, out, DATA_W: broadcast copy of `rom_dout`.
- `rdata_vld`, out, 2: per-requester ROM data valid.
- `res`, out, RES_W: registered MAC result.
- `res_vld`, out, 2: per-requester result valid.
- `ovf_sticky`, out, 2: per-requester sticky overflow.
- `ovf_clr`, in, 2: clears the corresponding sticky bit.

## Operation
- FSM states: IDLE, OWN0, OWN1 (encoding in package).
- IDLE:
  - If exactly one `req` bit is set → OWNk.
  - If both are set → grant the requester not served last. `last_owner` resets to 1, so requester 0 wins the first tie.
- OWNk: `gnt[k]`=1.
  - A beat is accepted in any cycle where `req[k]&gnt[k]`.
  - Beat counter increments per accepted beat; it clears on every grant change.
- OWNk → IDLE (`gnt` drops next cycle) when:
  - `req[k]`=0 in the current cycle, or
  - `MAX_BURST`≠0, beat count = `MAX_BURST`, and `req[1-k]`=1.
  - On this transition `last_owner`←k.
- IDLE lasts at least one cycle between owners (one bubble cycle). Owner switch latency is 2 cycles.
- Accepted beat handling:
  - `rom_addr`←`addr[k]` and `rom_en`←1, registered.
  - A 2-stage tag pipe carries {valid, k}.
  - If `opr_vld[k]`: `mac_in1`/`mac_in2` are driven combinationally from the owner's operands. `res`←`mac_out` and `res_vld[k]`←1 next cycle. `ovf_sticky[k]` |= `mac_ovf`.
- When no beat is accepted, `mac_in1`/`mac_in2` are 0, and `rom_en` and `rom_addr` hold their last values.
- In-flight tags always complete, even after the grant has moved. `rdata_vld` follows the tag, not the current `gnt`.
- `ovf_clr[k]` and a set event in the same cycle → set wins.

## Timing
- Reset values: `gnt`=0, `rom_en`=0, `rom_addr`=0, `rdata_vld`=0, `res`=0, `res_vld`=0, `ovf_sticky`=0, state=IDLE, `last_owner`=1, tag pipe empty.
- Grant latency: `req` rises at edge N → `gnt` is high after edge N+1.
- ROM latency: beat accepted in cycle c → `rom_addr` is valid after edge c+1, the ROM samples at edge c+2, and `rdata_vld[k]` is high in cycle c+2 for exactly one cycle.
- MAC latency: 1 cycle. `res_vld` is high in cycle c+1 for exactly one cycle.
- Throughput: one beat per cycle while the grant is held.
- Reset mid-operation: everything clears asynchronously. In-flight tags are dropped; no valid is issued for them after reset deasserts.
- Requester protocol violations are not checked:
  - `req` dropped before acceptance
  - `addr` changed while `req` is held and not yet accepted

## Structure
- `tpu_arb_pkg`:
  - FSM state typedef
  - `ADDR_W`/`DATA_W`/`RES_W` defaults
  - tag struct {vld, id}
- One sub-module, `arb_rr_pick`: combinational 2-way round-robin picker (`req`, `last_owner` → one-hot pick).
- The FSM, beat counter, tag pipe, and result/sticky registers stay in the top module.

## Test plan
- Single requester: `req[0]` held for 4 beats at addr 5,6,7,8 → `gnt[0]` after 1 cycle; `rdata_vld[0]` pulses 2 cycles after each accept; ROM words 5..8 in order.
- Simultaneous `req`=2'b11 out of reset → `gnt`=2'b01 first; after req0 drops, one idle cycle, then `gnt`=2'b10.
- `MAX_BURST`=4, both requesting continuously → alternating 4-beat bursts separated by one idle cycle; no beat lost or duplicated.
- Grant switch with in-flight reads: req0's last beat accepted in cycle c, then `gnt` moves to 1 → `rdata_vld[0]` still fires in c+2, and `rdata_vld[1]` never fires for req0's beat.
- MAC beat with operands forcing overflow → `res_vld[1]`=1 next cycle, `ovf_sticky`=2'b10; `ovf_clr[1]` in the same cycle as a new overflow → sticky stays 1.
- Assert `iRst` with 2 tags in flight → all outputs return to reset values immediately; no `rdata_vld` after release.
